// File: rtl/mimo_pkg.sv
// Shared helpers for the mimo library: count-width function, transfer-count
// struct and a configuration sanity check used at elaboration.
package mimo_pkg;

    // Width needed to hold values 0..n inclusive.
    function automatic int unsigned mimo_cntw(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Elements moved in one cycle; wide enough for any legal configuration.
    typedef struct packed {
        logic [15:0] enq_n;
        logic [15:0] deq_n;
    } mimo_xfer_t;

    // Depth must be a power of two and hold one full enqueue plus one full view.
    function automatic bit mimo_cfg_ok(input int unsigned depth, input int unsigned in_elems,
                                       input int unsigned out_elems);
        return (depth != 0) && ((depth & (depth - 1)) == 0) && (depth >= in_elems + out_elems);
    endfunction

endpackage

// File: rtl/mimo_rotator.sv
// Combinational window: presents OUT_ELEMS consecutive elements of the circular
// store starting at rd_ptr, wrapping at DEPTH_ELEMS-1 -> 0. Oldest in the LSBs.
module mimo_rotator
    import mimo_pkg::*;
#(
    parameter int unsigned ELEM_WIDTH  = 8,
    parameter int unsigned OUT_ELEMS   = 16,
    parameter int unsigned DEPTH_ELEMS = 32
) (
    input  logic [ELEM_WIDTH-1:0]           mem [DEPTH_ELEMS],
    input  logic [$clog2(DEPTH_ELEMS)-1:0]  rd_ptr,
    output logic [OUT_ELEMS*ELEM_WIDTH-1:0] data
);

    localparam int unsigned PW = $clog2(DEPTH_ELEMS);

    // Lane k reads mem[rd_ptr + k]; pointer arithmetic wraps naturally at PW bits.
    always_comb begin
        data = '0;
        for (int k = 0; k < int'(OUT_ELEMS); k++) begin
            data[k*ELEM_WIDTH +: ELEM_WIDTH] = mem[rd_ptr + PW'(k)];
        end
    end

endmodule

// File: rtl/mimo_gearbox.sv
// Variable-rate element gearbox over a circular element buffer.
// Enqueues 0..IN_ELEMS elements, dequeues 1..OUT_ELEMS elements per cycle.
// Optional build macro MIMO_GEARBOX_ERR_EN adds the sticky err_sticky[1:0] output.
module mimo_gearbox
    import mimo_pkg::*;
#(
    parameter int unsigned ELEM_WIDTH  = 8,
    parameter int unsigned IN_ELEMS    = 4,
    parameter int unsigned OUT_ELEMS   = 16,
    parameter int unsigned DEPTH_ELEMS = 32
) (
    input  logic                                 CLK,
    input  logic                                 nRST,
    input  logic                                 in_enq__ENA,
    output logic                                 in_enq__RDY,
    input  logic [IN_ELEMS*ELEM_WIDTH-1:0]       in_enq_v,
    input  logic [mimo_cntw(IN_ELEMS)-1:0]       in_enq_count,
    output logic [OUT_ELEMS*ELEM_WIDTH-1:0]      out_first,
    output logic                                 out_first__RDY,
    output logic [mimo_cntw(OUT_ELEMS)-1:0]      out_avail,
`ifdef MIMO_GEARBOX_ERR_EN
    output logic [1:0]                           err_sticky,
`endif
    input  logic                                 out_deq__ENA,
    output logic                                 out_deq__RDY,
    input  logic [mimo_cntw(OUT_ELEMS)-1:0]      out_deq_count
);

    localparam int unsigned PW = $clog2(DEPTH_ELEMS);
    localparam int unsigned CW = mimo_cntw(DEPTH_ELEMS);
    localparam int unsigned IW = mimo_cntw(IN_ELEMS);
    localparam int unsigned OW = mimo_cntw(OUT_ELEMS);

    if (!mimo_cfg_ok(DEPTH_ELEMS, IN_ELEMS, OUT_ELEMS)) begin : g_cfg_err
        $error("mimo_gearbox: DEPTH_ELEMS must be a power of 2 and >= IN_ELEMS+OUT_ELEMS");
    end

    logic [ELEM_WIDTH-1:0] mem [DEPTH_ELEMS];
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q,  count_d;

    logic       enq_fire, deq_legal, deq_fire;
    mimo_xfer_t xfer;

    // Handshake status derives from registered count only (no dequeue bypass).
    always_comb begin
        in_enq__RDY    = count_q <= CW'(DEPTH_ELEMS - IN_ELEMS);
        out_first__RDY = count_q != '0;
        out_deq__RDY   = count_q != '0;
        out_avail      = (count_q >= CW'(OUT_ELEMS)) ? OW'(OUT_ELEMS) : OW'(count_q);
    end

    // Qualify requests; out-of-range counts are dropped rather than corrupting state.
    always_comb begin
        enq_fire   = in_enq__ENA && in_enq__RDY && (in_enq_count <= IW'(IN_ELEMS));
        deq_legal  = (out_deq_count != '0) && (out_deq_count <= out_avail);
        deq_fire   = out_deq__ENA && out_deq__RDY && deq_legal;
        xfer.enq_n = enq_fire ? 16'(in_enq_count)  : 16'd0;
        xfer.deq_n = deq_fire ? 16'(out_deq_count) : 16'd0;
        wr_ptr_d   = wr_ptr_q + PW'(xfer.enq_n);
        rd_ptr_d   = rd_ptr_q + PW'(xfer.deq_n);
        count_d    = count_q + CW'(xfer.enq_n) - CW'(xfer.deq_n);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Write-lane demux: input lane i lands at wr_ptr+i, wrapping modulo depth.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < int'(DEPTH_ELEMS); i++) begin
                mem[i] <= '0;
            end
        end else if (enq_fire) begin
            for (int i = 0; i < int'(IN_ELEMS); i++) begin
                if (IW'(i) < in_enq_count) begin
                    mem[wr_ptr_q + PW'(i)] <= in_enq_v[i*ELEM_WIDTH +: ELEM_WIDTH];
                end
            end
        end
    end

    mimo_rotator #(
        .ELEM_WIDTH  (ELEM_WIDTH),
        .OUT_ELEMS   (OUT_ELEMS),
        .DEPTH_ELEMS (DEPTH_ELEMS)
    ) u_rotator (
        .mem    (mem),
        .rd_ptr (rd_ptr_q),
        .data   (out_first)
    );

`ifdef MIMO_GEARBOX_ERR_EN
    logic [1:0] err_q;
    logic       enq_err, deq_err;

    // Flag requests that were dropped; bits clear only on reset.
    always_comb begin
        enq_err = in_enq__ENA && !in_enq__RDY;
        deq_err = out_deq__ENA && (!out_deq__RDY || !deq_legal);
    end

    // Sticky error capture.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err_q <= '0;
        end else begin
            err_q <= err_q | {deq_err, enq_err};
        end
    end

    assign err_sticky = err_q;
`endif

endmodule

// File: tb/tb_mimo_gearbox.sv
// Self-checking bench for mimo_gearbox: directed scenarios followed by random
// traffic, all compared against a queue-based element model.
module tb_mimo_gearbox;

    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic         in_enq__ENA = 1'b0;
    logic         in_enq__RDY;
    logic [31:0]  in_enq_v = '0;
    logic [2:0]   in_enq_count = '0;
    logic [127:0] out_first;
    logic         out_first__RDY;
    logic [4:0]   out_avail;
    logic         out_deq__ENA = 1'b0;
    logic         out_deq__RDY;
    logic [4:0]   out_deq_count = '0;
`ifdef MIMO_GEARBOX_ERR_EN
    logic [1:0]   err_sticky;
`endif

    mimo_gearbox #(
        .ELEM_WIDTH  (8),
        .IN_ELEMS    (4),
        .OUT_ELEMS   (16),
        .DEPTH_ELEMS (32)
    ) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .in_enq__ENA    (in_enq__ENA),
        .in_enq__RDY    (in_enq__RDY),
        .in_enq_v       (in_enq_v),
        .in_enq_count   (in_enq_count),
        .out_first      (out_first),
        .out_first__RDY (out_first__RDY),
        .out_avail      (out_avail),
`ifdef MIMO_GEARBOX_ERR_EN
        .err_sticky     (err_sticky),
`endif
        .out_deq__ENA   (out_deq__ENA),
        .out_deq__RDY   (out_deq__RDY),
        .out_deq_count  (out_deq_count)
    );

    always #5 CLK = ~CLK;

    int          errors = 0;
    int          checks = 0;
    byte unsigned q[$];
    byte unsigned seq = 0;
    bit  [1:0]   m_err = '0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every observable output against the element queue.
    task automatic check_model(input string tag);
        int           sz;
        int           av;
        logic [127:0] exp;
        logic [127:0] mask;
        sz   = q.size();
        av   = (sz < 16) ? sz : 16;
        exp  = '0;
        mask = '0;
        for (int k = 0; k < av; k++) begin
            exp[k*8 +: 8]  = q[k];
            mask[k*8 +: 8] = 8'hFF;
        end
        chk({tag, ".enq_rdy"},   in_enq__RDY,       (32 - sz) >= 4);
        chk({tag, ".first_rdy"}, out_first__RDY,    sz != 0);
        chk({tag, ".deq_rdy"},   out_deq__RDY,      sz != 0);
        chk({tag, ".avail"},     out_avail,         av);
        chk({tag, ".first"},     out_first & mask,  exp);
`ifdef MIMO_GEARBOX_ERR_EN
        chk({tag, ".err"},       err_sticky,        m_err);
`endif
    endtask

    // One clock of traffic; the model applies the same rules to its queue.
    task automatic step(input string tag, input bit ena, input logic [31:0] v, input int cnt,
                        input bit dena, input int dcnt);
        int sz;
        int av;
        bit enq_ok;
        bit deq_ok;
        sz     = q.size();
        av     = (sz < 16) ? sz : 16;
        enq_ok = ena && ((32 - sz) >= 4) && (cnt <= 4);
        deq_ok = dena && (sz != 0) && (dcnt >= 1) && (dcnt <= av);
        if (ena && !((32 - sz) >= 4)) m_err[0] = 1'b1;
        if (dena && !deq_ok) m_err[1] = 1'b1;
        in_enq__ENA   = ena;
        in_enq_v      = v;
        in_enq_count  = 3'(cnt);
        out_deq__ENA  = dena;
        out_deq_count = 5'(dcnt);
        @(posedge CLK);
        #1;
        if (deq_ok) repeat (dcnt) void'(q.pop_front());
        if (enq_ok) for (int i = 0; i < cnt; i++) q.push_back(v[i*8 +: 8]);
        in_enq__ENA  = 1'b0;
        out_deq__ENA = 1'b0;
        check_model(tag);
    endtask

    // Enqueue cnt sequential bytes from the running counter.
    task automatic enq_seq(input string tag, input int cnt, input bit dena, input int dcnt);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < cnt; i++) begin
            v[i*8 +: 8] = seq;
            seq++;
        end
        step(tag, 1'b1, v, cnt, dena, dcnt);
    endtask

    task automatic drain(input string tag);
        while (q.size() != 0) begin
            step(tag, 1'b0, '0, 0, 1'b1, (q.size() < 16) ? q.size() : 16);
        end
    endtask

    task automatic pulse_reset();
        #2;
        nRST = 1'b0;
        #1;
        q.delete();
        m_err = '0;
        check_model("rst_async");
        chk("rst_first_zero", out_first, 128'h0);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        // Reset state.
        #12;
        check_model("reset");
        chk("reset_first", out_first, 128'h0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Basic: bytes 0x00..0x0F in four full enqueues.
        seq = 8'h00;
        for (int i = 0; i < 4; i++) enq_seq("basic_enq", 4, 1'b0, 0);
        chk("basic_avail", out_avail, 16);
        chk("basic_first", out_first, 128'h0F0E0D0C0B0A09080706050403020100);
        step("basic_deq", 1'b0, '0, 0, 1'b1, 16);
        chk("basic_empty", out_deq__RDY, 1'b0);

        // Ragged enqueue counts.
        step("rag0", 1'b1, 32'h00A2A1A0, 3, 1'b0, 0);
        step("rag1", 1'b1, 32'hDEADBEEF, 0, 1'b0, 0);
        step("rag2", 1'b1, 32'h000000A3, 1, 1'b0, 0);
        step("rag3", 1'b1, 32'h0000A5A4, 2, 1'b0, 0);
        chk("rag_avail", out_avail, 6);
        chk("rag_lane0", out_first[7:0], 8'hA0);
        chk("rag_lane5", out_first[47:40], 8'hA5);
        step("rag_deq", 1'b0, '0, 0, 1'b1, 2);
        chk("rag_lane0_after", out_first[7:0], 8'hA2);
        drain("rag_drain");

        // Full: 29 elements blocks enqueue; one dequeue reopens it.
        for (int i = 0; i < 7; i++) enq_seq("full_enq", 4, 1'b0, 0);
        enq_seq("full_enq1", 1, 1'b0, 0);
        chk("full_rdy", in_enq__RDY, 1'b0);
        enq_seq("full_ignored", 4, 1'b0, 0);
        chk("full_avail", out_avail, 16);
        step("full_deq1", 1'b0, '0, 0, 1'b1, 1);
        chk("full_rdy_back", in_enq__RDY, 1'b1);
        drain("full_drain");

        // Concurrent enqueue/dequeue at count 10 across several pointer wraps.
        enq_seq("conc_fill", 4, 1'b0, 0);
        enq_seq("conc_fill", 4, 1'b0, 0);
        enq_seq("conc_fill", 2, 1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            enq_seq("conc", 4, 1'b1, 4);
            chk("conc_avail", out_avail, 10);
            chk("conc_span", 8'(out_first[79:72] - out_first[7:0]), 8'd9);
        end

        // Asynchronous reset mid-stream with count 10.
        pulse_reset();

`ifdef MIMO_GEARBOX_ERR_EN
        // Illegal dequeue count sets bit1 and it holds until reset.
        enq_seq("err_fill", 3, 1'b0, 0);
        step("err_deq5", 1'b0, '0, 0, 1'b1, 5);
        chk("err_avail", out_avail, 3);
        chk("err_bits", err_sticky, 2'b10);
        step("err_hold", 1'b0, '0, 0, 1'b0, 0);
        chk("err_held", err_sticky, 2'b10);
        pulse_reset();
`endif

        // Random traffic, including illegal dequeue counts and blocked enqueues.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] v;
            int          sz;
            int          cnt;
            int          dmax;
            v    = $urandom;
            sz   = q.size();
            cnt  = int'($urandom_range(0, 4));
            dmax = ((sz < 16) ? sz : 16) + 1;
            if (dmax > 16) dmax = 16;
            step("rand", ($urandom_range(0, 3) != 0), v, cnt,
                 ($urandom_range(0, 2) == 0), int'($urandom_range(0, dmax)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
